// File: rtl/stg_pkg.sv
// Shared definitions for the wave spawn scheduler.
//   - stg_state_e : scheduler FSM states
//   - ENT_*       : bit positions of the fields inside a wave-table word
//   - TYPE_*      : enemy type codes carried in the type field
//   - sat_inc4    : 4-bit increment that sticks at 15
package stg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_LOAD      = 4'd2,
    ST_WAIT_DLY  = 4'd3,
    ST_WAIT_SLOT = 4'd4,
    ST_SPAWN     = 4'd5,
    ST_CLEAR     = 4'd6,
    ST_DRAIN     = 4'd7,
    ST_DONE      = 4'd8
  } stg_state_e;

  localparam int unsigned ENT_EOT     = 31;
  localparam int unsigned ENT_EOW     = 30;
  localparam int unsigned ENT_TYPE_HI = 29;
  localparam int unsigned ENT_TYPE_LO = 28;
  localparam int unsigned ENT_X_HI    = 25;
  localparam int unsigned ENT_X_LO    = 16;
  localparam int unsigned ENT_DLY_HI  = 15;
  localparam int unsigned ENT_DLY_LO  = 0;

  localparam logic [1:0] TYPE_GRUNT = 2'd0;
  localparam logic [1:0] TYPE_FAST  = 2'd1;
  localparam logic [1:0] TYPE_TANK  = 2'd2;
  localparam logic [1:0] TYPE_BOSS  = 2'd3;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/alive_counter.sv
// Live-enemy counter: one increment and two independent decrements may all
// land in the same cycle. The result clamps at 0 (never wraps to 15) and is
// capped at MAX.
//   clk     : system clock
//   rst_i   : synchronous active-high reset
//   clear_i : synchronous clear (same effect as reset)
//   inc_i   : +1 this cycle
//   dec1_i  : -1 this cycle
//   dec2_i  : -1 this cycle
//   count_o : current count
module alive_counter #(
  parameter int unsigned MAX = 8
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       inc_i,
  input  logic       dec1_i,
  input  logic       dec2_i,
  output logic [3:0] count_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic [4:0] up;
  logic [4:0] down;
  logic [4:0] diff;

  always_comb begin
    up      = {1'b0, count_q} + {4'd0, inc_i};
    down    = {4'd0, dec1_i} + {4'd0, dec2_i};
    diff    = up - down;
    count_d = diff[3:0];
    if (up < down) begin
      count_d = 4'd0;
    end else if (diff > 5'(MAX)) begin
      count_d = 4'(MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || clear_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wave_spawn_scheduler.sv
// Walks a wave table in an external synchronous ROM and issues enemy spawn
// requests over a valid/ready handshake, pacing them by per-entry tick
// delays, a live-enemy limit and end-of-wave / end-of-table markers.
//   clk           : system clock
//   hard_reset    : synchronous active-high reset (wins over game_reset)
//   game_en       : play enable from the game FSM, 0 = pause
//   game_reset    : one-cycle restart pulse from the game FSM
//   tick          : one-cycle frame strobe, time base for entry delays
//   tbl_addr      : ROM address
//   tbl_data      : ROM word, valid one cycle after tbl_addr
//   spawn_valid   : spawn request
//   spawn_ready   : enemy datapath accepts the request
//   spawn_x       : spawn x coordinate
//   spawn_type    : enemy type code
//   enemy_killed  : pulse, one live enemy destroyed
//   enemy_escaped : pulse, one live enemy left the screen
//   alive_count   : current live enemies
//   wave_num      : current wave index, saturates at 15
//   all_done      : table exhausted and field clear
module wave_spawn_scheduler
  import stg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ENTRY_W   = 32,
  parameter int unsigned MAX_ALIVE = 8
) (
  input  logic               clk,
  input  logic               hard_reset,
  input  logic               game_en,
  input  logic               game_reset,
  input  logic               tick,
  output logic [ADDR_W-1:0]  tbl_addr,
  input  logic [ENTRY_W-1:0] tbl_data,
  output logic               spawn_valid,
  input  logic               spawn_ready,
  output logic [9:0]         spawn_x,
  output logic [1:0]         spawn_type,
  input  logic               enemy_killed,
  input  logic               enemy_escaped,
  output logic [3:0]         alive_count,
  output logic [3:0]         wave_num,
  output logic               all_done
);

  stg_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic [9:0]        x_q;
  logic [1:0]        type_q;
  logic              eot_q;
  logic              eow_q;
  logic [15:0]       dly_q;
  logic [3:0]        wave_q;
  logic              done_q;

  logic [3:0]        alive_w;
  logic              spawn_fire;
  logic              slot_free;
  logic              last_addr;
  logic              unused_bits;

  assign spawn_fire  = valid_q & spawn_ready;
  assign slot_free   = (32'(alive_w) < MAX_ALIVE);
  // The address never wraps: the last ROM slot ends the table.
  assign last_addr   = &addr_q;
  assign unused_bits = ^tbl_data[27:26];

  alive_counter #(.MAX(MAX_ALIVE)) u_alive (
    .clk     (clk),
    .rst_i   (hard_reset),
    .clear_i (game_reset),
    .inc_i   (spawn_fire),
    .dec1_i  (enemy_killed),
    .dec2_i  (enemy_escaped),
    .count_o (alive_w)
  );

  always_ff @(posedge clk) begin
    if (hard_reset || game_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      type_q  <= '0;
      eot_q   <= 1'b0;
      eow_q   <= 1'b0;
      dly_q   <= '0;
      wave_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (game_en) state_q <= ST_FETCH;
        end
        // Address is already on tbl_addr; the ROM registers it this cycle.
        ST_FETCH: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          x_q     <= tbl_data[ENT_X_HI:ENT_X_LO];
          type_q  <= tbl_data[ENT_TYPE_HI:ENT_TYPE_LO];
          eot_q   <= tbl_data[ENT_EOT];
          eow_q   <= tbl_data[ENT_EOW];
          dly_q   <= tbl_data[ENT_DLY_HI:ENT_DLY_LO];
          state_q <= (tbl_data[ENT_DLY_HI:ENT_DLY_LO] != 16'd0) ? ST_WAIT_DLY
                                                                 : ST_WAIT_SLOT;
        end
        // Delay counts only qualifying ticks; a pause freezes it.
        ST_WAIT_DLY: begin
          if (tick && game_en) begin
            dly_q <= dly_q - 16'd1;
            if (dly_q == 16'd1) state_q <= ST_WAIT_SLOT;
          end
        end
        ST_WAIT_SLOT: begin
          if (game_en && slot_free) begin
            valid_q <= 1'b1;
            state_q <= ST_SPAWN;
          end
        end
        // Request is held regardless of game_en until accepted.
        ST_SPAWN: begin
          if (spawn_ready) begin
            valid_q <= 1'b0;
            if (eot_q || last_addr) begin
              state_q <= ST_DRAIN;
            end else if (eow_q) begin
              state_q <= ST_CLEAR;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= ST_FETCH;
            end
          end
        end
        ST_CLEAR: begin
          if (alive_w == 4'd0) begin
            wave_q  <= sat_inc4(wave_q);
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (alive_w == 4'd0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tbl_addr    = addr_q;
  assign spawn_valid = valid_q;
  assign spawn_x     = x_q;
  assign spawn_type  = type_q;
  assign alive_count = alive_w;
  assign wave_num    = wave_q;
  assign all_done    = done_q;

endmodule

// File: tb/tb_wave_spawn_scheduler.sv
// Directed bench for wave_spawn_scheduler: one table-driven cycle sequence
// plus hand-written sequences for the multi-cycle corner cases. A second
// instance with MAX_ALIVE=2 covers the slot-limit behaviour.
module tb_wave_spawn_scheduler;
  import stg_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hard_reset, game_en, game_reset, tick;
  logic        spawn_ready, enemy_killed, enemy_escaped;

  logic [5:0]  addr1, addr2;
  logic [31:0] data1, data2;
  logic        valid1, valid2;
  logic [9:0]  x1, x2;
  logic [1:0]  type1, type2;
  logic [3:0]  alive1, alive2, wave1, wave2;
  logic        done1, done2;

  logic [31:0] rom [64];

  always_ff @(posedge clk) begin
    data1 <= rom[addr1];
    data2 <= rom[addr2];
  end

  wave_spawn_scheduler #(.ADDR_W(6), .ENTRY_W(32), .MAX_ALIVE(8)) dut (
    .clk(clk), .hard_reset(hard_reset), .game_en(game_en), .game_reset(game_reset),
    .tick(tick), .tbl_addr(addr1), .tbl_data(data1), .spawn_valid(valid1),
    .spawn_ready(spawn_ready), .spawn_x(x1), .spawn_type(type1),
    .enemy_killed(enemy_killed), .enemy_escaped(enemy_escaped),
    .alive_count(alive1), .wave_num(wave1), .all_done(done1)
  );

  wave_spawn_scheduler #(.ADDR_W(6), .ENTRY_W(32), .MAX_ALIVE(2)) dut2 (
    .clk(clk), .hard_reset(hard_reset), .game_en(game_en), .game_reset(game_reset),
    .tick(tick), .tbl_addr(addr2), .tbl_data(data2), .spawn_valid(valid2),
    .spawn_ready(spawn_ready), .spawn_x(x2), .spawn_type(type2),
    .enemy_killed(enemy_killed), .enemy_escaped(enemy_escaped),
    .alive_count(alive2), .wave_num(wave2), .all_done(done2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ent(input logic eot, input logic eow, input logic [1:0] t,
                                      input logic [9:0] x, input logic [15:0] d);
    return {eot, eow, t, 2'b00, x, d};
  endfunction

  task automatic idle_inputs();
    game_en = 1'b0; game_reset = 1'b0; tick = 1'b0;
    spawn_ready = 1'b0; enemy_killed = 1'b0; enemy_escaped = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    hard_reset = 1'b1;
    cyc();
    hard_reset = 1'b0;
  endtask

  typedef struct {
    logic       en, rdy, kill, esc;
    logic       exp_vld;
    logic [9:0] exp_x;
    logic [1:0] exp_t;
    logic [3:0] exp_alive;
    logic       exp_done;
  } vec_t;

  vec_t vt [9];

  task automatic setv(input int i, input logic en, input logic rdy, input logic kill,
                      input logic esc, input logic vld, input logic [9:0] x,
                      input logic [1:0] t, input logic [3:0] alive, input logic done);
    vt[i].en = en; vt[i].rdy = rdy; vt[i].kill = kill; vt[i].esc = esc;
    vt[i].exp_vld = vld; vt[i].exp_x = x; vt[i].exp_t = t;
    vt[i].exp_alive = alive; vt[i].exp_done = done;
  endtask

  // Delay run: the frame-strobe phase only advances while playing, so a
  // pause shifts the spawn by exactly the paused cycles.
  task automatic run_dly(input bit pause, output int first);
    int p;
    p = 0;
    first = -1;
    spawn_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      game_en = !(pause && c >= 8 && c < 18);
      tick = game_en && (p % 4 == 3);
      if (game_en) p++;
      cyc();
      if (valid1 && first < 0) first = c;
    end
    tick = 1'b0;
  endtask

  initial begin
    int first;
    int seen;
    hard_reset = 1'b0;
    idle_inputs();

    // ---- reset state ----
    do_reset();
    chk("reset_valid", int'(valid1), 0);
    chk("reset_addr",  int'(addr1),  0);
    chk("reset_alive", int'(alive1), 0);
    chk("reset_wave",  int'(wave1),  0);
    chk("reset_done",  int'(done1),  0);
    chk("reset_x",     int'(x1),     0);

    // ---- scenario 1: single eot entry, table-driven ----
    rom[0] = ent(1'b1, 1'b0, TYPE_FAST, 10'd100, 16'd0);
    setv(0, 1, 1, 0, 0, 0, 10'd0,   2'd0, 4'd0, 0);
    setv(1, 1, 1, 0, 0, 0, 10'd0,   2'd0, 4'd0, 0);
    setv(2, 1, 1, 0, 0, 0, 10'd100, 2'd1, 4'd0, 0);
    setv(3, 1, 1, 0, 0, 1, 10'd100, 2'd1, 4'd0, 0);
    setv(4, 1, 1, 0, 0, 0, 10'd100, 2'd1, 4'd1, 0);
    setv(5, 1, 1, 0, 0, 0, 10'd100, 2'd1, 4'd1, 0);
    setv(6, 1, 1, 1, 0, 0, 10'd100, 2'd1, 4'd0, 0);
    setv(7, 1, 1, 0, 0, 0, 10'd100, 2'd1, 4'd0, 1);
    setv(8, 1, 1, 0, 0, 0, 10'd100, 2'd1, 4'd0, 1);
    for (int i = 0; i < 9; i++) begin
      game_en = vt[i].en; spawn_ready = vt[i].rdy;
      enemy_killed = vt[i].kill; enemy_escaped = vt[i].esc;
      cyc();
      chk($sformatf("s1_valid[%0d]", i), int'(valid1), int'(vt[i].exp_vld));
      chk($sformatf("s1_x[%0d]", i),     int'(x1),     int'(vt[i].exp_x));
      chk($sformatf("s1_type[%0d]", i),  int'(type1),  int'(vt[i].exp_t));
      chk($sformatf("s1_alive[%0d]", i), int'(alive1), int'(vt[i].exp_alive));
      chk($sformatf("s1_done[%0d]", i),  int'(done1),  int'(vt[i].exp_done));
    end

    // ---- scenario 2: delay of 5 ticks, with and without a 10-cycle pause ----
    do_reset();
    rom[0] = ent(1'b1, 1'b0, TYPE_TANK, 10'd200, 16'd5);
    run_dly(1'b0, first);
    chk("s2_first_valid", first, 20);
    chk("s2_x", int'(x1), 200);
    chk("s2_type", int'(type1), 2);
    do_reset();
    rom[0] = ent(1'b1, 1'b0, TYPE_TANK, 10'd200, 16'd5);
    run_dly(1'b1, first);
    chk("s2_paused_first_valid", first, 30);

    // ---- scenario 3: stalled handshake with game_en toggling ----
    do_reset();
    rom[0] = ent(1'b1, 1'b0, TYPE_BOSS, 10'd517, 16'd0);
    game_en = 1'b1;
    spawn_ready = 1'b0;
    repeat (4) cyc();
    chk("s3_valid_up", int'(valid1), 1);
    for (int k = 0; k < 7; k++) begin
      game_en = k[0];
      cyc();
      chk($sformatf("s3_hold[%0d]", k), int'({valid1, x1, type1}), int'({1'b1, 10'd517, 2'd3}));
      chk($sformatf("s3_alive[%0d]", k), int'(alive1), 0);
    end
    game_en = 1'b0;
    spawn_ready = 1'b1;
    cyc();
    chk("s3_valid_drop", int'(valid1), 0);
    chk("s3_alive_one", int'(alive1), 1);
    cyc();
    chk("s3_alive_still_one", int'(alive1), 1);

    // ---- scenario 4: MAX_ALIVE=2 instance, three back-to-back entries ----
    do_reset();
    rom[0] = ent(1'b0, 1'b0, TYPE_GRUNT, 10'd10, 16'd0);
    rom[1] = ent(1'b0, 1'b0, TYPE_GRUNT, 10'd20, 16'd0);
    rom[2] = ent(1'b1, 1'b0, TYPE_GRUNT, 10'd30, 16'd0);
    game_en = 1'b1;
    spawn_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 11; c++) begin
      cyc();
      if (valid2) seen++;
    end
    chk("s4_two_spawns", seen, 2);
    chk("s4_alive_full", int'(alive2), 2);
    chk("s4_addr", int'(addr2), 2);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (valid2) seen++;
    end
    chk("s4_blocked_in_slot_wait", seen, 0);
    enemy_killed = 1'b1;
    cyc();
    chk("s4_alive_after_kill", int'(alive2), 1);
    enemy_killed = 1'b0;
    cyc();
    chk("s4_third_valid", int'(valid2), 1);
    chk("s4_third_x", int'(x2), 30);
    enemy_killed = 1'b1;
    cyc();
    chk("s4_fire_and_kill_alive", int'(alive2), 1);
    chk("s4_fire_and_kill_valid", int'(valid2), 0);
    enemy_killed = 1'b0;

    // ---- scenario 5: end of wave holds the next fetch until clear ----
    do_reset();
    rom[0] = ent(1'b0, 1'b0, TYPE_GRUNT, 10'd40, 16'd0);
    rom[1] = ent(1'b0, 1'b1, TYPE_TANK,  10'd50, 16'd0);
    rom[2] = ent(1'b1, 1'b0, TYPE_FAST,  10'd60, 16'd0);
    game_en = 1'b1;
    spawn_ready = 1'b1;
    repeat (9) cyc();
    chk("s5_alive_two", int'(alive1), 2);
    repeat (4) cyc();
    chk("s5_addr_held", int'(addr1), 1);
    chk("s5_wave_zero", int'(wave1), 0);
    enemy_killed = 1'b1;
    cyc();
    chk("s5_alive_one", int'(alive1), 1);
    enemy_escaped = 1'b1;
    cyc();
    chk("s5_double_dec_clamps", int'(alive1), 0);
    chk("s5_addr_still_held", int'(addr1), 1);
    enemy_killed = 1'b0;
    enemy_escaped = 1'b0;
    cyc();
    chk("s5_wave_one", int'(wave1), 1);
    chk("s5_addr_two", int'(addr1), 2);
    repeat (3) cyc();
    chk("s5_next_valid", int'(valid1), 1);
    chk("s5_next_x", int'(x1), 60);

    // ---- scenario 6: game_reset in SPAWN and in DONE ----
    do_reset();
    rom[0] = ent(1'b0, 1'b0, TYPE_FAST, 10'd70, 16'd0);
    rom[1] = ent(1'b1, 1'b0, TYPE_TANK, 10'd80, 16'd0);
    game_en = 1'b1;
    spawn_ready = 1'b1;
    repeat (5) cyc();
    spawn_ready = 1'b0;
    repeat (3) cyc();
    chk("s6_in_spawn", int'(valid1), 1);
    chk("s6_alive_before", int'(alive1), 1);
    game_reset = 1'b1;
    cyc();
    game_reset = 1'b0;
    chk("s6_spawn_valid", int'(valid1), 0);
    chk("s6_spawn_alive", int'(alive1), 0);
    chk("s6_spawn_addr",  int'(addr1),  0);
    chk("s6_spawn_done",  int'(done1),  0);
    repeat (3) cyc();
    chk("s6_restart_not_yet", int'(valid1), 0);
    cyc();
    chk("s6_restart_valid", int'(valid1), 1);
    chk("s6_restart_x", int'(x1), 70);
    spawn_ready = 1'b1;
    for (int i = 0; i < 40 && !done1; i++) begin
      enemy_killed = (alive1 != 4'd0);
      cyc();
    end
    enemy_killed = 1'b0;
    chk("s6_reached_done", int'(done1), 1);
    game_reset = 1'b1;
    cyc();
    game_reset = 1'b0;
    chk("s6_done_cleared", int'(done1),  0);
    chk("s6_done_addr",    int'(addr1),  0);
    chk("s6_done_alive",   int'(alive1), 0);
    chk("s6_done_valid",   int'(valid1), 0);
    chk("s6_done_wave",    int'(wave1),  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
